load_store_unit: RTL and testbench
==================================

# load_store_unit

Multi-cycle load/store unit sitting directly downstream of the 32-bit ALU in the single-cycle RISC core. It consumes the ALU result as the effective address plus rs2 as store data, and runs a valid/ready transaction on the data-memory bus. It stalls the core until the access completes, then returns byte/halfword/word load data, sign- or zero-extended, for writeback.

## Interface
- N, 32: data/address width (byte-lane logic fixed for 32).
- TIMEOUT, 255: max cycles waiting for mem_ready before error (1..65535).

- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  current instruction is a load/store.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V size/sign field.
- req_addr  in  N  effective address (ALU ADD result).
- req_wdata  in  N  store data (rs2).
- req_ready  out  1  LSU idle, request accepted this cycle if req_valid.
- stall  out  1  core must hold PC/state.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  N  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned/illegal/bus error/timeout, valid with rsp_valid.
- mem_valid  out  1  bus request.
- mem_we  out  1  bus write.
- mem_addr  out  N  word-aligned address (req_addr & ~3).
- mem_wdata  out  N  lane-replicated store data.
- mem_be  out  4  byte enables.
- mem_ready  in  1  bus accepts/completes request this cycle.
- mem_rdata  in  N  read data, valid with mem_ready.
- mem_err  in  1  bus error, valid with mem_ready.

## Operation
- States: IDLE, BUS, RESP. Reset → IDLE.
- IDLE: req_ready=1. Accept on req_valid: register we, funct3, addr[1:0], aligned addr, be, wdata. Legal → BUS; misaligned/illegal → RESP with err, no bus cycle.
- BUS: mem_valid=1, outputs stable. mem_ready → capture mem_rdata/mem_err, → RESP. Timeout counter reaches TIMEOUT with no mem_ready → err, → RESP.
- RESP: rsp_valid=1 for exactly one cycle, → IDLE.
- Legal funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW. Others illegal.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]≠0.
- mem_be: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111. Loads drive the same be.
- mem_wdata: byte replicated ×4, half replicated ×2, word as-is.
- Load data: mem_rdata >> (8*addr[1:0]), then sign-extend (LB/LH) or zero-extend (LBU/LHU).

## Timing
- Reset values: req_ready=1, stall=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_valid=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0.
- All mem_* and rsp_* are registered. req_ready and stall are combinational from state.
- stall = (IDLE & req_valid) | BUS. Stall is 0 in RESP, so the core retires with rsp_rdata that cycle. req_ready=0 in RESP blocks re-acceptance.
- Latency: accept at T, mem_valid from T+1, mem_ready at T+k (k≥1), rsp_valid at T+k+1. Minimum is 2 cycles. Misaligned/illegal: rsp_valid at T+1.
- Timeout counter clears on entry to BUS and increments each cycle mem_ready=0. On reaching TIMEOUT, mem_valid drops the next cycle.
- If mem_ready and timeout occur in the same cycle, mem_ready wins.
- The master never drops mem_valid without mem_ready except on timeout or reset.
- Reset asserted mid-transaction: immediately IDLE, mem_valid=0, no rsp_valid.

## Structure
- Package lsu_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum lsu_state_t, default TIMEOUT.
- Sub-module lsu_align (combinational): be generation, write-lane replication, misalign/illegal detect, read shift and extension. The top module holds the FSM, the registers and the timeout counter.

## Test plan
- SW addr 0x104, wdata 0xDEADBEEF, mem_ready at T+1 → mem_addr 0x104, be 1111, wdata 0xDEADBEEF; rsp_valid at T+2, rsp_err=0, stall high T..T+1.
- LB addr 0x203, mem_rdata 0x80FF_1234 → be 1000, rsp_rdata 0xFFFFFF80. Same case with LBU → 0x00000080.
- LH addr 0x202, mem_rdata 0x8001_0000 → be 1100, rsp_rdata 0xFFFF8001. SH addr 0x202, wdata 0x0000ABCD → wdata 0xABCDABCD, be 1100.
- LW addr 0x101 → no mem_valid, rsp_valid at T+1, rsp_err=1, rsp_rdata=0. funct3=011 → same response.
- TIMEOUT=4 with mem_ready held low → mem_valid for 4 cycles, then rsp_err=1. Separately, mem_err=1 with mem_ready → rsp_err=1.
- rst_n pulsed low while in BUS → mem_valid=0 immediately, no rsp_valid. The next request after reset completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: RISC-V funct3 encodings,
// FSM state type and the default bus timeout.
package lsu_pkg;

  localparam int unsigned LSU_TIMEOUT_DEFAULT = 255;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory valid/ready bus between the load/store unit (master) and memory (slave).
interface load_store_unit_if #(
  parameter int N = 32
);
  logic         mem_valid;
  logic         mem_we;
  logic [N-1:0] mem_addr;
  logic [N-1:0] mem_wdata;
  logic [3:0]   mem_be;
  logic         mem_ready;
  logic [N-1:0] mem_rdata;
  logic         mem_err;

  modport master (
    output mem_valid, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ready, mem_rdata, mem_err
  );

  modport slave (
    input  mem_valid, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ready, mem_rdata, mem_err
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: request-side enables/replication/legality and
// response-side load shift with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  req_funct3_i,
  input  logic        req_we_i,
  input  logic [1:0]  req_off_i,
  input  logic [31:0] req_wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        err_o,
  input  logic [2:0]  rsp_funct3_i,
  input  logic [1:0]  rsp_off_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] rdata_o
);

  logic        legal;
  logic        misaligned;
  logic [31:0] shifted;

  // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    be_o       = 4'b0000;
    wdata_o    = req_wdata_i;
    misaligned = 1'b0;
    case (req_funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << req_off_i;
        wdata_o = {4{req_wdata_i[7:0]}};
      end
      2'b01: begin
        be_o       = 4'b0011 << req_off_i;
        wdata_o    = {2{req_wdata_i[15:0]}};
        misaligned = req_off_i[0];
      end
      2'b10: begin
        be_o       = 4'b1111;
        misaligned = (req_off_i != 2'b00);
      end
      default: ;
    endcase

    if (req_we_i) legal = req_funct3_i inside {F3_B, F3_H, F3_W};
    else          legal = req_funct3_i inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};

    err_o = !legal || misaligned;
  end

  always_comb begin
    shifted = rdata_i >> {rsp_off_i, 3'b000};
    case (rsp_funct3_i)
      F3_B:    rdata_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    rdata_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   rdata_o = {24'b0, shifted[7:0]};
      F3_HU:   rdata_o = {16'b0, shifted[15:0]};
      default: rdata_o = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: accepts one core request, runs one data-memory
// bus transaction (or rejects it), and returns a one-cycle extended response.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int          N       = 32,
  parameter int unsigned TIMEOUT = LSU_TIMEOUT_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  input  logic          req_we,
  input  logic [2:0]    req_funct3,
  input  logic [N-1:0]  req_addr,
  input  logic [N-1:0]  req_wdata,
  output logic          req_ready,
  output logic          stall,
  output logic          rsp_valid,
  output logic [N-1:0]  rsp_rdata,
  output logic          rsp_err,
  load_store_unit_if.master mem
);

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  lsu_state_t   state_q, state_d;
  logic         we_q, we_d;
  logic [2:0]   funct3_q, funct3_d;
  logic [1:0]   off_q, off_d;
  logic [N-1:0] addr_q, addr_d;
  logic [3:0]   be_q, be_d;
  logic [N-1:0] wdata_q, wdata_d;
  logic [15:0]  cnt_q, cnt_d;
  logic         rsp_err_q, rsp_err_d;
  logic [N-1:0] rsp_rdata_q, rsp_rdata_d;

  logic [3:0]   al_be;
  logic [31:0]  al_wdata;
  logic         al_err;
  logic [31:0]  al_rdata;

  lsu_align u_align (
    .req_funct3_i (req_funct3),
    .req_we_i     (req_we),
    .req_off_i    (req_addr[1:0]),
    .req_wdata_i  (req_wdata),
    .be_o         (al_be),
    .wdata_o      (al_wdata),
    .err_o        (al_err),
    .rsp_funct3_i (funct3_q),
    .rsp_off_i    (off_q),
    .rdata_i      (mem.mem_rdata),
    .rdata_o      (al_rdata)
  );

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          off_d    = req_addr[1:0];
          addr_d   = {req_addr[N-1:2], 2'b00};
          be_d     = al_be;
          wdata_d  = al_wdata;
          cnt_d    = '0;
          if (al_err) begin
            // Rejected requests answer straight away without touching the bus.
            state_d     = RESP;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d = BUS;
          end
        end
      end
      BUS: begin
        if (mem.mem_ready) begin
          state_d     = RESP;
          rsp_err_d   = mem.mem_err;
          rsp_rdata_d = (we_q || mem.mem_err) ? '0 : al_rdata;
        end else begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == TIMEOUT_LAST) begin
            state_d     = RESP;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end
      RESP: begin
        state_d     = IDLE;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      addr_q      <= '0;
      be_q        <= 4'b0000;
      wdata_q     <= '0;
      cnt_q       <= '0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready     = (state_q == IDLE);
  assign stall         = ((state_q == IDLE) && req_valid) || (state_q == BUS);
  assign rsp_valid     = (state_q == RESP);
  assign rsp_err       = rsp_err_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign mem.mem_valid = (state_q == BUS);
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_be    = be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed transactions, expected
// responses queued at drive time and compared when rsp_valid pulses.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  always #5 clk = ~clk;

  load_store_unit_if #(.N(32)) mem_if ();

  load_store_unit #(.N(32), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .stall      (stall),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem        (mem_if)
  );

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Scoreboard: every response pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    rsp_t e;
    if (rst_n && rsp_valid) begin
      check("rsp_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("resp_stall", {31'b0, stall}, 32'd0);
        check("resp_req_ready", {31'b0, req_ready}, 32'd0);
      end
    end
  end

  task automatic drive_req(input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    #1;
    check("accept_ready", {31'b0, req_ready}, 32'd1);
    check("accept_stall", {31'b0, stall}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata, input int delay,
                         input logic merr, input logic bus, input logic [3:0] exp_be,
                         input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                         input logic exp_err);
    exp_q.push_back('{err: exp_err, rdata: exp_rdata});
    drive_req(we, f3, addr, wdata);
    if (!bus) begin
      check("reject_no_bus", {31'b0, mem_if.mem_valid}, 32'd0);
      check("reject_rsp_t1", {31'b0, rsp_valid}, 32'd1);
      return;
    end
    check("bus_valid", {31'b0, mem_if.mem_valid}, 32'd1);
    check("bus_we", {31'b0, mem_if.mem_we}, {31'b0, we});
    check("bus_addr", mem_if.mem_addr, addr & ~32'd3);
    check("bus_be", {28'b0, mem_if.mem_be}, {28'b0, exp_be});
    if (we) check("bus_wdata", mem_if.mem_wdata, exp_wdata);
    check("bus_stall", {31'b0, stall}, 32'd1);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check("bus_hold", {31'b0, mem_if.mem_valid}, 32'd1);
    end
    mem_if.mem_ready = 1'b1;
    mem_if.mem_rdata = rdata;
    mem_if.mem_err   = merr;
    @(negedge clk);
    mem_if.mem_ready = 1'b0;
    mem_if.mem_err   = 1'b0;
    check("rsp_latency", {31'b0, rsp_valid}, 32'd1);
    check("bus_released", {31'b0, mem_if.mem_valid}, 32'd0);
  endtask

  initial begin
    rst_n            = 1'b0;
    req_valid        = 1'b0;
    req_we           = 1'b0;
    req_funct3       = 3'b000;
    req_addr         = '0;
    req_wdata        = '0;
    mem_if.mem_ready = 1'b0;
    mem_if.mem_rdata = '0;
    mem_if.mem_err   = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_mem_valid", {31'b0, mem_if.mem_valid}, 32'd0);
    check("rst_mem_we", {31'b0, mem_if.mem_we}, 32'd0);
    check("rst_mem_addr", mem_if.mem_addr, 32'd0);
    check("rst_mem_wdata", mem_if.mem_wdata, 32'd0);
    check("rst_mem_be", {28'b0, mem_if.mem_be}, 32'd0);
    rst_n = 1'b1;

    //      we    f3     addr          wdata         rdata         dly merr bus  be       exp_wdata     exp_rdata     err
    run_txn(1'b1, F3_W,  32'h0000_0104, 32'hDEAD_BEEF, 32'h0,        0, 1'b0, 1'b1, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0);
    run_txn(1'b0, F3_B,  32'h0000_0203, 32'h0,         32'h80FF_1234, 0, 1'b0, 1'b1, 4'b1000, 32'h0,         32'hFFFF_FF80, 1'b0);
    run_txn(1'b0, F3_BU, 32'h0000_0203, 32'h0,         32'h80FF_1234, 1, 1'b0, 1'b1, 4'b1000, 32'h0,         32'h0000_0080, 1'b0);
    run_txn(1'b0, F3_H,  32'h0000_0202, 32'h0,         32'h8001_0000, 0, 1'b0, 1'b1, 4'b1100, 32'h0,         32'hFFFF_8001, 1'b0);
    run_txn(1'b1, F3_H,  32'h0000_0202, 32'h0000_ABCD, 32'h0,        2, 1'b0, 1'b1, 4'b1100, 32'hABCD_ABCD, 32'h0000_0000, 1'b0);
    run_txn(1'b1, F3_B,  32'h0000_0201, 32'h0000_00A5, 32'h0,        0, 1'b0, 1'b1, 4'b0010, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0);
    run_txn(1'b0, F3_HU, 32'h0000_0200, 32'h0,         32'h1234_F00D, 1, 1'b0, 1'b1, 4'b0011, 32'h0,         32'h0000_F00D, 1'b0);
    run_txn(1'b0, F3_W,  32'h0000_0300, 32'h0,         32'h1234_5678, 2, 1'b0, 1'b1, 4'b1111, 32'h0,         32'h1234_5678, 1'b0);
    run_txn(1'b0, F3_W,  32'h0000_0101, 32'h0,         32'h0,        0, 1'b0, 1'b0, 4'b0000, 32'h0,         32'h0000_0000, 1'b1);
    run_txn(1'b0, F3_H,  32'h0000_0103, 32'h0,         32'h0,        0, 1'b0, 1'b0, 4'b0000, 32'h0,         32'h0000_0000, 1'b1);
    run_txn(1'b0, 3'b011, 32'h0000_0100, 32'h0,        32'h0,        0, 1'b0, 1'b0, 4'b0000, 32'h0,         32'h0000_0000, 1'b1);
    run_txn(1'b1, F3_BU, 32'h0000_0100, 32'h0,         32'h0,        0, 1'b0, 1'b0, 4'b0000, 32'h0,         32'h0000_0000, 1'b1);
    run_txn(1'b0, F3_W,  32'h0000_0400, 32'h0,         32'h5555_AAAA, 1, 1'b1, 1'b1, 4'b1111, 32'h0,         32'h0000_0000, 1'b1);

    // Timeout: mem_ready never arrives, bus held for exactly TO cycles.
    exp_q.push_back('{err: 1'b1, rdata: 32'h0});
    drive_req(1'b0, F3_W, 32'h0000_0500, 32'h0);
    check("to_valid_0", {31'b0, mem_if.mem_valid}, 32'd1);
    for (int i = 1; i < TO; i++) begin
      @(negedge clk);
      check("to_valid_hold", {31'b0, mem_if.mem_valid}, 32'd1);
      check("to_no_rsp", {31'b0, rsp_valid}, 32'd0);
    end
    @(negedge clk);
    check("to_valid_drop", {31'b0, mem_if.mem_valid}, 32'd0);
    check("to_rsp", {31'b0, rsp_valid}, 32'd1);

    // Reset while waiting on the bus: transaction is abandoned silently.
    drive_req(1'b0, F3_W, 32'h0000_0600, 32'h0);
    check("rst_mid_bus", {31'b0, mem_if.mem_valid}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", {31'b0, mem_if.mem_valid}, 32'd0);
    check("rst_mid_rsp", {31'b0, rsp_valid}, 32'd0);
    check("rst_mid_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_no_rsp", {31'b0, rsp_valid}, 32'd0);
    end
    run_txn(1'b0, F3_W,  32'h0000_0600, 32'h0,         32'hCAFE_F00D, 0, 1'b0, 1'b1, 4'b1111, 32'h0,         32'hCAFE_F00D, 1'b0);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
